// File: rtl/adder_sub_bist.sv
// Built-in self-test sequencer for the WIDTH-bit adder/subtractor: walks every
// {select, A, B} vector in ascending order and checks the returned sum/carry.
module adder_sub_bist #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     dut_A,
  output logic [WIDTH-1:0]     dut_B,
  output logic                 dut_select,
  input  logic [WIDTH-1:0]     dut_sum,
  input  logic                 dut_carry_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     error_count,
  output logic [2*WIDTH:0]     first_fail,
  output logic                 first_fail_valid
);

  localparam int VW = 2 * WIDTH + 1;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [VW-1:0] LAST_VEC   = '1;
  localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t          state, state_nx;
  logic [VW-1:0]   v;
  logic [CW-1:0]   settle_cnt;
  logic            launch;
  logic            mismatch;
  logic [WIDTH:0]  ref_result;

  // Golden (WIDTH+1)-bit result; subtract is A + ~B + 1 so carry means "no borrow".
  function automatic logic [WIDTH:0] ref_model(input logic sel,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] ax;
    ax = {1'b0, a};
    if (sel) ref_model = ax + {1'b0, ~b} + (WIDTH+1)'(1);
    else     ref_model = ax + {1'b0, b};
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] x);
    sat_inc = (x == '1) ? x : x + ERR_W'(1);
  endfunction

  assign dut_select = v[VW-1];
  assign dut_A      = v[VW-2:WIDTH];
  assign dut_B      = v[WIDTH-1:0];

  assign ref_result = ref_model(dut_select, dut_A, dut_B);
  assign mismatch   = ({dut_carry_out, dut_sum} != ref_result);
  assign launch     = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = SETTLE;
      SETTLE:     if (settle_cnt == SETTLE_END) state_nx = CHECK;
      CHECK:      state_nx = (v == LAST_VEC) ? DONE : SETTLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SETTLE) || (state == CHECK);
    done = (state == DONE);
    pass = (state == DONE) && (error_count == '0);
  end

  // Vector index, settle timer and result capture; everything clears on reset
  // so an aborted sweep leaves nothing behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v                <= '0;
      settle_cnt       <= '0;
      error_count      <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
    end else if (launch) begin
      v                <= '0;
      settle_cnt       <= '0;
      error_count      <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
    end else if (state == SETTLE) begin
      if (settle_cnt != SETTLE_END) settle_cnt <= settle_cnt + CW'(1);
    end else if (state == CHECK) begin
      if (mismatch) begin
        error_count <= sat_inc(error_count);
        if (!first_fail_valid) begin
          first_fail       <= v;
          first_fail_valid <= 1'b1;
        end
      end
      if (v != LAST_VEC) begin
        v          <= v + VW'(1);
        settle_cnt <= '0;
      end
    end
  end

endmodule
